mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 Clk  input  1  system clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high; forces the controller to reset state immediately.
REQ-003 F  input  4  opcode (IR[15:12]) from the datapath.
REQ-004 N, Z  input  1 each  accumulator negative and zero flags from the datapath.
REQ-005 Mem_Rdy  input  1  memory completion strobe; the access in progress completes in a cycle with Mem_Rdy=1.
REQ-006 Start  input  1  resume request, sampled only in HALT.
REQ-007 X_sel, Y_sel, Addr_sel  output  1 each  datapath mux selects: X 0=Acc 1=PC; Y 0=Data_in 1=IR; Addr 0=PC 1=IR.
REQ-008 PC_En, IR_En, Acc_En  output  1 each  datapath register load enables.
REQ-009 M  output  2  ALU function: 00=Y, 01=X+Y, 10=X+1, 11=X-Y.
REQ-010 Rd, Wr  output  1 each  memory read and write requests.
REQ-011 Halted, Illegal  output  1 each  status: in HALT; last halt was caused by an undefined opcode.

Function
REQ-012 States: FETCH, EXEC, HALT; encoded in a state register; all outputs decode combinationally from state, F, N, Z and Mem_Rdy.
REQ-013 FETCH: Addr_sel=0, Rd=1, X_sel=1, M=10; IR_En=PC_En=Mem_Rdy; move to EXEC when Mem_Rdy=1, else stay in FETCH.
REQ-014 EXEC LDA (0): Addr_sel=1, Rd=1, Y_sel=0, M=00, Acc_En=Mem_Rdy.
REQ-015 EXEC STA (1): Addr_sel=1, X_sel=0, Wr=1; no register enable.
REQ-016 EXEC ADD (2) / SUB (3): Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, M=01 / 11, Acc_En=Mem_Rdy.
REQ-017 For opcodes 0-3, EXEC holds Rd/Wr and all selects stable until Mem_Rdy=1, then goes to FETCH.
REQ-018 EXEC JMP (4): Y_sel=1, M=00, PC_En=1; no memory access, no wait; go to FETCH next cycle.
REQ-019 EXEC JGE (5): acts as JMP when N=0; when N=1, no enables asserted; go to FETCH next cycle.
REQ-020 EXEC JNE (6): acts as JMP when Z=0; when Z=1, no enables asserted; go to FETCH next cycle.
REQ-021 EXEC STP (7): no enables asserted; go to HALT; Illegal cleared.
REQ-022 EXEC opcodes 8-F: no enables asserted; go to HALT; Illegal set.
REQ-023 HALT: all enables, Rd and Wr are 0; Halted=1; Start=1 moves to FETCH and clears Illegal; otherwise stay in HALT.
REQ-024 Rd and Wr are never both 1; at most one of PC_En/Acc_En is 1 in any EXEC cycle.
REQ-025 Undriven selects and M are 0 (Acc, Data_in, PC, Y).
REQ-026 Each instruction costs 2 cycles with zero wait states; every Mem_Rdy=0 cycle during an access adds one cycle.

Reset
REQ-027 While Reset=1: state=FETCH; Illegal=0; PC_En, IR_En, Acc_En, Rd, Wr and Halted forced to 0, regardless of Mem_Rdy.
REQ-028 Reset asserted mid-access (EXEC with Rd/Wr high) aborts the access immediately; after release the first cycle is FETCH with Addr_sel=0.

Verification
REQ-029 Reset release, Mem_Rdy=1, memory {0:0x0005, 5:0x1234} -> cycle1 FETCH (IR_En=PC_En=1, M=10); cycle2 EXEC with Addr_sel=1, Rd=1, M=00, Acc_En=1.
REQ-030 STA with Mem_Rdy low for 3 cycles -> Wr=1, Addr_sel=1, X_sel=0 held 4 cycles; FETCH on the 5th cycle; no enable asserted during the wait.
REQ-031 JGE with N=1, then JGE with N=0 -> first: PC_En=0 in EXEC; second: PC_En=1, Y_sel=1, M=00.
REQ-032 JNE with Z=1, then JNE with Z=0 -> PC_En=0, then PC_En=1; each instruction takes exactly 2 cycles.
REQ-033 F=7 in EXEC -> HALT with Halted=1, Illegal=0; outputs stay idle for 10 cycles; Start pulse -> FETCH next cycle.
REQ-034 F=0xA in EXEC -> HALT with Illegal=1; Reset pulse -> Illegal=0, state FETCH; Reset during ADD wait -> Rd drops to 0 immediately.

Source files
------------

// File: rtl/mu0_control_if.sv
// Control/datapath signal bundle for the MU0 controller.
// slave = controller side, master = datapath/memory side.
interface mu0_control_if;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Mem_Rdy;
    logic       Start;
    logic       X_sel;
    logic       Y_sel;
    logic       Addr_sel;
    logic       PC_En;
    logic       IR_En;
    logic       Acc_En;
    logic [1:0] M;
    logic       Rd;
    logic       Wr;
    logic       Halted;
    logic       Illegal;

    modport slave (
        input  F, N, Z, Mem_Rdy, Start,
        output X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Illegal
    );

    modport master (
        output F, N, Z, Mem_Rdy, Start,
        input  X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted, Illegal
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 controller: FETCH/EXEC/HALT sequencer with outputs decoded from state,
// opcode, flags and Mem_Rdy; Reset gates all enables and memory strobes at once.
module mu0_control (
    input  logic          Clk,
    input  logic          Reset,
    mu0_control_if.slave  bus
);
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t r_state;
    logic   r_illegal;

    logic       w_x_sel;
    logic       w_y_sel;
    logic       w_addr_sel;
    logic       w_pc_en;
    logic       w_ir_en;
    logic       w_acc_en;
    logic [1:0] w_m;
    logic       w_rd;
    logic       w_wr;
    logic       w_halted;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (bus.Mem_Rdy)
                        r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.F[3]) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end else if (bus.F == 4'd7) begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b0;
                    end else if (bus.F[2]) begin
                        r_state <= S_FETCH;
                    end else if (bus.Mem_Rdy) begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (bus.Start) begin
                        r_state   <= S_FETCH;
                        r_illegal <= 1'b0;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_x_sel    = 1'b0;
        w_y_sel    = 1'b0;
        w_addr_sel = 1'b0;
        w_pc_en    = 1'b0;
        w_ir_en    = 1'b0;
        w_acc_en   = 1'b0;
        w_m        = 2'b00;
        w_rd       = 1'b0;
        w_wr       = 1'b0;
        w_halted   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_x_sel = 1'b1;
                w_m     = 2'b10;
                w_rd    = 1'b1;
                w_ir_en = bus.Mem_Rdy;
                w_pc_en = bus.Mem_Rdy;
            end
            S_EXEC: begin
                unique case (bus.F)
                    4'd0: begin
                        w_addr_sel = 1'b1;
                        w_rd       = 1'b1;
                        w_acc_en   = bus.Mem_Rdy;
                    end
                    4'd1: begin
                        w_addr_sel = 1'b1;
                        w_wr       = 1'b1;
                    end
                    4'd2, 4'd3: begin
                        w_addr_sel = 1'b1;
                        w_rd       = 1'b1;
                        w_m        = bus.F[0] ? 2'b11 : 2'b01;
                        w_acc_en   = bus.Mem_Rdy;
                    end
                    4'd4, 4'd5, 4'd6: begin
                        // JMP always, JGE on !N, JNE on !Z; untaken jumps leave everything idle
                        if ((bus.F == 4'd4) || (bus.F == 4'd5 && !bus.N) || (bus.F == 4'd6 && !bus.Z)) begin
                            w_y_sel = 1'b1;
                            w_pc_en = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT: w_halted = 1'b1;
            default: ;
        endcase
        if (Reset) begin
            w_pc_en  = 1'b0;
            w_ir_en  = 1'b0;
            w_acc_en = 1'b0;
            w_rd     = 1'b0;
            w_wr     = 1'b0;
            w_halted = 1'b0;
        end
    end

    assign bus.X_sel    = w_x_sel;
    assign bus.Y_sel    = w_y_sel;
    assign bus.Addr_sel = w_addr_sel;
    assign bus.PC_En    = w_pc_en;
    assign bus.IR_En    = w_ir_en;
    assign bus.Acc_En   = w_acc_en;
    assign bus.M        = w_m;
    assign bus.Rd       = w_rd;
    assign bus.Wr       = w_wr;
    assign bus.Halted   = w_halted;
    assign bus.Illegal  = r_illegal;
endmodule

// File: tb/tb_mu0_control.sv
// Directed-vector bench for mu0_control; control outputs are packed as
// {X_sel,Y_sel,Addr_sel,PC_En,IR_En,Acc_En,M[1:0],Rd,Wr,Halted,Illegal}.
module tb_mu0_control;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mu0_control_if bus ();

    mu0_control dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] C_RESET      = 12'b1000_0010_0000;
    localparam logic [11:0] C_FETCH_RDY  = 12'b1001_1010_1000;
    localparam logic [11:0] C_FETCH_WAIT = 12'b1000_0010_1000;
    localparam logic [11:0] C_LDA_RDY    = 12'b0010_0100_1000;
    localparam logic [11:0] C_STA        = 12'b0010_0000_0100;
    localparam logic [11:0] C_ADD_WAIT   = 12'b0010_0001_1000;
    localparam logic [11:0] C_ADD_RDY    = 12'b0010_0101_1000;
    localparam logic [11:0] C_SUB_RDY    = 12'b0010_0111_1000;
    localparam logic [11:0] C_JUMP       = 12'b0101_0000_0000;
    localparam logic [11:0] C_IDLE       = 12'b0000_0000_0000;
    localparam logic [11:0] C_HALT       = 12'b0000_0000_0010;
    localparam logic [11:0] C_HALT_ILL   = 12'b0000_0000_0011;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [11:0] w_ctl;
    assign w_ctl = {bus.X_sel, bus.Y_sel, bus.Addr_sel, bus.PC_En, bus.IR_En, bus.Acc_En,
                    bus.M, bus.Rd, bus.Wr, bus.Halted, bus.Illegal};

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the decoded outputs.
    task automatic step(input logic [3:0] f, input logic n, input logic z, input logic rdy,
                        input logic st, input string tag, input logic [11:0] exp);
        @(negedge clk);
        rst         = 1'b0;
        bus.F       = f;
        bus.N       = n;
        bus.Z       = z;
        bus.Mem_Rdy = rdy;
        bus.Start   = st;
        #1;
        check(tag, w_ctl, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.F = 4'd0; bus.N = 1'b0; bus.Z = 1'b0; bus.Mem_Rdy = 1'b1; bus.Start = 1'b0;
        #1;
        check("reset_hold", w_ctl, C_RESET);

        // Load from address 5 with zero wait states
        step(4'h0, 0, 0, 1, 0, "lda_fetch", C_FETCH_RDY);
        step(4'h0, 0, 0, 1, 0, "lda_exec", C_LDA_RDY);

        // STA with three wait cycles
        step(4'h1, 0, 0, 1, 0, "sta_fetch", C_FETCH_RDY);
        for (int i = 0; i < 3; i++)
            step(4'h1, 0, 0, 0, 0, "sta_wait", C_STA);
        step(4'h1, 0, 0, 1, 0, "sta_done", C_STA);
        step(4'h2, 0, 0, 1, 0, "sta_next_fetch", C_FETCH_RDY);

        step(4'h2, 0, 0, 0, 0, "add_wait", C_ADD_WAIT);
        step(4'h2, 0, 0, 1, 0, "add_done", C_ADD_RDY);
        step(4'h3, 0, 0, 1, 0, "sub_fetch", C_FETCH_RDY);
        step(4'h3, 0, 0, 1, 0, "sub_done", C_SUB_RDY);

        step(4'h4, 0, 0, 0, 0, "fetch_wait", C_FETCH_WAIT);
        step(4'h4, 0, 0, 1, 0, "jmp_fetch", C_FETCH_RDY);
        step(4'h4, 0, 0, 0, 0, "jmp_exec", C_JUMP);

        step(4'h5, 1, 0, 1, 0, "jge_n1_fetch", C_FETCH_RDY);
        step(4'h5, 1, 0, 0, 0, "jge_n1_exec", C_IDLE);
        step(4'h5, 0, 0, 1, 0, "jge_n0_fetch", C_FETCH_RDY);
        step(4'h5, 0, 0, 0, 0, "jge_n0_exec", C_JUMP);

        step(4'h6, 0, 1, 1, 0, "jne_z1_fetch", C_FETCH_RDY);
        step(4'h6, 0, 1, 0, 0, "jne_z1_exec", C_IDLE);
        step(4'h6, 0, 0, 1, 0, "jne_z0_fetch", C_FETCH_RDY);
        step(4'h6, 0, 0, 0, 0, "jne_z0_exec", C_JUMP);

        // STP: halt, stay idle, resume on Start
        step(4'h7, 0, 0, 1, 0, "stp_fetch", C_FETCH_RDY);
        step(4'h7, 0, 0, 1, 0, "stp_exec", C_IDLE);
        for (int i = 0; i < 10; i++)
            step(4'h0, 0, 0, 1, 0, "stp_halt", C_HALT);
        step(4'h0, 0, 0, 1, 1, "stp_start", C_HALT);
        step(4'hA, 0, 0, 1, 0, "resume_fetch", C_FETCH_RDY);

        // Undefined opcode: Illegal set, cleared by Reset
        step(4'hA, 0, 0, 1, 0, "ill_exec", C_IDLE);
        step(4'hA, 0, 0, 1, 0, "ill_halt", C_HALT_ILL);
        step(4'hA, 0, 0, 1, 0, "ill_halt_hold", C_HALT_ILL);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ill_reset", w_ctl, C_RESET);

        // Undefined opcode: Illegal cleared by Start
        step(4'hF, 0, 0, 1, 0, "ill2_fetch", C_FETCH_RDY);
        step(4'hF, 0, 0, 1, 0, "ill2_exec", C_IDLE);
        step(4'h0, 0, 0, 1, 1, "ill2_start", C_HALT_ILL);
        step(4'h2, 0, 0, 1, 0, "ill2_fetch_clear", C_FETCH_RDY);

        // Reset in the middle of an ADD wait aborts the read at once
        step(4'h2, 0, 0, 0, 0, "abort_wait", C_ADD_WAIT);
        #2;
        rst = 1'b1;
        #1;
        check("abort_reset", w_ctl, C_RESET);
        step(4'h2, 0, 0, 1, 0, "abort_refetch", C_FETCH_RDY);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
